// File: rtl/match_collect.sv
// Walks target groups, reads four matched lanes per group and emits the lanes that pass the ratio test.
// One memory read per group. Pairs use valid/ready flow control, and a stalled consumer holds the pass.
module match_collect #(
  parameter int RATIO_NUM = 8,
  parameter int RATIO_DEN = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [8:0]  tar_group_num,
  output logic [8:0]  mem_addr,
  input  logic [48:0] matched_dout_0,
  input  logic [48:0] matched_dout_1,
  input  logic [48:0] matched_dout_2,
  input  logic [48:0] matched_dout_3,
  input  logic [18:0] tar_rc_0,
  input  logic [18:0] tar_rc_1,
  input  logic [18:0] tar_rc_2,
  input  logic [18:0] tar_rc_3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [18:0] out_tar_rc,
  output logic [18:0] out_img_rc,
  output logic [14:0] out_best_dist,
  output logic [10:0] match_count,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, ADDR, CAPT, EVAL, DONE} state_t;

  state_t      state;
  logic [8:0]  grp;
  logic [8:0]  ngrp;
  logic [1:0]  lane;
  logic [48:0] md [4];
  logic [18:0] tr [4];

  logic [48:0] md_in [4];
  logic [18:0] tr_in [4];
  logic [1:0]  nxt_lane;
  logic        cur_pass;
  logic        nxt_pass;
  logic        group_end;
  logic [9:0]  grp_inc;

  // Products are formed at 20 bits so the largest 15-bit distance times the ratio never wraps.
  function automatic logic lane_pass(input logic [48:0] e);
    logic [19:0] lhs;
    logic [19:0] rhs;
    lhs = 20'(e[29:15]) * 20'(RATIO_DEN);
    rhs = 20'(e[14:0]) * 20'(RATIO_NUM);
    return (e[29:15] != 15'h7FFF) && (lhs < rhs);
  endfunction

  assign md_in[0] = matched_dout_0;
  assign md_in[1] = matched_dout_1;
  assign md_in[2] = matched_dout_2;
  assign md_in[3] = matched_dout_3;
  assign tr_in[0] = tar_rc_0;
  assign tr_in[1] = tar_rc_1;
  assign tr_in[2] = tar_rc_2;
  assign tr_in[3] = tar_rc_3;

  assign nxt_lane  = lane + 2'd1;
  assign cur_pass  = lane_pass(md[lane]);
  assign nxt_pass  = lane_pass(md[nxt_lane]);
  assign grp_inc   = {1'b0, grp} + 10'd1;
  assign group_end = (state == EVAL) && (lane == 2'd3) && (out_valid ? out_ready : !cur_pass);

  assign mem_addr = grp;
  assign busy     = (state == ADDR) || (state == CAPT) || (state == EVAL);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      grp           <= '0;
      ngrp          <= '0;
      lane          <= '0;
      out_valid     <= 1'b0;
      out_tar_rc    <= '0;
      out_img_rc    <= '0;
      out_best_dist <= '0;
      match_count   <= '0;
      for (int i = 0; i < 4; i++) begin
        md[i] <= '0;
        tr[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            grp         <= '0;
            match_count <= '0;
            ngrp        <= tar_group_num;
            state       <= (tar_group_num == 9'd0) ? DONE : ADDR;
          end
        end
        ADDR: state <= CAPT;
        CAPT: begin
          for (int i = 0; i < 4; i++) begin
            md[i] <= md_in[i];
            tr[i] <= tr_in[i];
          end
          lane  <= '0;
          state <= EVAL;
        end
        EVAL: begin
          if (out_valid) begin
            if (out_ready) begin
              if (match_count != 11'h7FF) match_count <= match_count + 11'd1;
              if (lane == 2'd3) begin
                out_valid <= 1'b0;
              end else begin
                // Look ahead one lane so back-to-back passing lanes stream without a bubble.
                lane      <= nxt_lane;
                out_valid <= nxt_pass;
                if (nxt_pass) begin
                  out_tar_rc    <= tr[nxt_lane];
                  out_img_rc    <= md[nxt_lane][48:30];
                  out_best_dist <= md[nxt_lane][29:15];
                end
              end
            end
          end else if (cur_pass) begin
            out_valid     <= 1'b1;
            out_tar_rc    <= tr[lane];
            out_img_rc    <= md[lane][48:30];
            out_best_dist <= md[lane][29:15];
          end else if (lane != 2'd3) begin
            lane <= nxt_lane;
          end
          if (group_end) begin
            grp   <= grp_inc[8:0];
            state <= (grp_inc == {1'b0, ngrp}) ? DONE : ADDR;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_collect.sv
// Drives directed and random collection passes and compares against a queue-based reference model.
module tb_match_collect;
  localparam int RNUM = 8;
  localparam int RDEN = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  tar_group_num;
  logic [8:0]  mem_addr;
  logic [48:0] matched_dout_0, matched_dout_1, matched_dout_2, matched_dout_3;
  logic [18:0] tar_rc_0, tar_rc_1, tar_rc_2, tar_rc_3;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_tar_rc;
  logic [18:0] out_img_rc;
  logic [14:0] out_best_dist;
  logic [10:0] match_count;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [48:0] mm [4][512];
  logic [18:0] tm [4][512];
  logic [52:0] exp_q [$];

  match_collect #(.RATIO_NUM(RNUM), .RATIO_DEN(RDEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tar_group_num(tar_group_num),
    .mem_addr(mem_addr),
    .matched_dout_0(matched_dout_0), .matched_dout_1(matched_dout_1),
    .matched_dout_2(matched_dout_2), .matched_dout_3(matched_dout_3),
    .tar_rc_0(tar_rc_0), .tar_rc_1(tar_rc_1), .tar_rc_2(tar_rc_2), .tar_rc_3(tar_rc_3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tar_rc(out_tar_rc), .out_img_rc(out_img_rc), .out_best_dist(out_best_dist),
    .match_count(match_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories, one cycle of latency.
  always @(posedge clk) begin
    matched_dout_0 <= mm[0][mem_addr];
    matched_dout_1 <= mm[1][mem_addr];
    matched_dout_2 <= mm[2][mem_addr];
    matched_dout_3 <= mm[3][mem_addr];
    tar_rc_0 <= tm[0][mem_addr];
    tar_rc_1 <= tm[1][mem_addr];
    tar_rc_2 <= tm[2][mem_addr];
    tar_rc_3 <= tm[3][mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] mk(input int img, input int best, input int sec);
    return {19'(img), 15'(best), 15'(sec)};
  endfunction

  function automatic bit model_pass(input logic [48:0] e);
    int b, s;
    b = int'(e[29:15]);
    s = int'(e[14:0]);
    return (b != 32767) && (b * RDEN < s * RNUM);
  endfunction

  task automatic set_group(input int g, input int b0, input int s0, input int b1, input int s1,
                           input int b2, input int s2, input int b3, input int s3);
    mm[0][g] = mk($urandom_range(0, 524287), b0, s0);
    mm[1][g] = mk($urandom_range(0, 524287), b1, s1);
    mm[2][g] = mk($urandom_range(0, 524287), b2, s2);
    mm[3][g] = mk($urandom_range(0, 524287), b3, s3);
    for (int l = 0; l < 4; l++) tm[l][g] = 19'($urandom_range(0, 524287));
  endtask

  task automatic fill_random(input int n);
    int k, s, b;
    for (int g = 0; g < n; g++) begin
      for (int l = 0; l < 4; l++) begin
        case ($urandom_range(0, 3))
          0: begin b = 32767; s = $urandom_range(0, 32767); end
          1: begin s = $urandom_range(0, 32767); b = $urandom_range(0, 32767); end
          2: begin s = $urandom_range(1, 32767); b = $urandom_range(0, s); end
          default: begin k = $urandom_range(1, 6553); s = 5 * k; b = 4 * k - $urandom_range(0, 1); end
        endcase
        mm[l][g] = mk($urandom_range(0, 524287), b, s);
        tm[l][g] = 19'($urandom_range(0, 524287));
      end
    end
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready held low for the first 5 valid cycles
  task automatic run_pass(input int n, input int mode, input string tag);
    logic [52:0] pay, prev_pay, e53;
    logic [48:0] e;
    bit pv, pr, r, finished;
    int hs, stall, last_addr, exp_cnt;
    exp_q.delete();
    for (int g = 0; g < n; g++)
      for (int l = 0; l < 4; l++) begin
        e = mm[l][g];
        if (model_pass(e)) exp_q.push_back({tm[l][g], e[48:30], e[29:15]});
      end
    exp_cnt = exp_q.size();
    @(negedge clk);
    start = 1'b1;
    tar_group_num = 9'(n);
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    tar_group_num = 9'($urandom_range(0, 511));
    chk({tag, "/addr0"}, 64'(mem_addr), 64'd0);
    chk({tag, "/busy"}, 64'(busy), 64'd1);
    hs = 0; stall = 5; pv = 0; pr = 0; last_addr = 0; finished = 0; prev_pay = '0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      pay = {out_tar_rc, out_img_rc, out_best_dist};
      if (pv && !pr) begin
        chk({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "/hold_payload"}, 64'(pay), 64'(prev_pay));
      end
      if (busy && int'(mem_addr) != last_addr) begin
        chk({tag, "/addr_step"}, 64'(mem_addr), 64'(last_addr + 1));
        last_addr = int'(mem_addr);
      end
      chk({tag, "/count_live"}, 64'(match_count), 64'((hs > 2047) ? 2047 : hs));
      if (done) begin
        finished = 1;
        chk({tag, "/valid_at_done"}, 64'(out_valid), 64'd0);
      end else begin
        case (mode)
          0: r = 1'b1;
          1: r = 1'($urandom_range(0, 1));
          default: begin
            r = !(out_valid && stall > 0);
            if (out_valid && stall > 0) stall--;
          end
        endcase
        out_ready = r;
        if (out_valid && r) begin
          if (exp_q.size() == 0) chk({tag, "/extra_pair"}, 64'(pay), 64'd0);
          else begin
            e53 = exp_q.pop_front();
            chk({tag, "/pair"}, 64'(pay), 64'(e53));
          end
          hs++;
        end
        pv = out_valid; pr = r; prev_pay = pay;
        @(negedge clk);
      end
    end
    chk({tag, "/done_seen"}, 64'(finished), 64'd1);
    chk({tag, "/pairs_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "/last_addr"}, 64'(last_addr), 64'(n - 1));
    chk({tag, "/count_final"}, 64'(match_count), 64'(exp_cnt));
    chk({tag, "/busy_done"}, 64'(busy), 64'd0);
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "/done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, "/count_hold"}, 64'(match_count), 64'(exp_cnt));
  endtask

  initial begin
    for (int l = 0; l < 4; l++)
      for (int a = 0; a < 512; a++) begin
        mm[l][a] = '0;
        tm[l][a] = '0;
      end
    rst_n = 1'b0; start = 1'b0; tar_group_num = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst/state", 64'({out_valid, busy, done}), 64'd0);
    chk("rst/addr", 64'(mem_addr), 64'd0);
    chk("rst/count", 64'(match_count), 64'd0);
    chk("rst/payload", 64'({out_tar_rc, out_img_rc, out_best_dist}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero groups: straight to a done pulse, no pairs.
    start = 1'b1; tar_group_num = 9'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero/done", 64'(done), 64'd1);
    chk("zero/busy", 64'(busy), 64'd0);
    chk("zero/valid", 64'(out_valid), 64'd0);
    chk("zero/count", 64'(match_count), 64'd0);
    @(negedge clk);
    chk("zero/done_drop", 64'(done), 64'd0);
    chk("zero/valid2", 64'(out_valid), 64'd0);

    // Mixed lanes: only lanes 0 and 3 pass.
    set_group(0, 100, 200, 90, 100, 32767, 32767, 0, 1);
    run_pass(1, 0, "mixed");
    chk("mixed/count2", 64'(match_count), 64'd2);

    // Ratio boundary: 800 vs 800 rejected, 790 vs 800 accepted, near-max 20-bit products.
    set_group(0, 80, 100, 79, 100, 26213, 32767, 0, 0);
    run_pass(1, 0, "bound");
    chk("bound/count2", 64'(match_count), 64'd2);

    // Consumer stalls for 5 cycles on the first pair.
    set_group(0, 1, 100, 2, 100, 3, 100, 4, 100);
    run_pass(1, 2, "stall");
    chk("stall/count4", 64'(match_count), 64'd4);

    // Three groups, every lane passes.
    for (int g = 0; g < 3; g++) set_group(g, g + 1, 1000, 10, 500, 7, 9, 0, 32767);
    run_pass(3, 0, "three");
    chk("three/count12", 64'(match_count), 64'd12);

    // Reset while evaluating group 1.
    @(negedge clk);
    out_ready = 1'b1; start = 1'b1; tar_group_num = 9'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !(mem_addr == 9'd1 && out_valid); i++) @(negedge clk);
    chk("rstmid/reach", 64'(mem_addr == 9'd1 && out_valid), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstmid/valid", 64'(out_valid), 64'd0);
    chk("rstmid/idle", 64'({busy, done}), 64'd0);
    chk("rstmid/addr", 64'(mem_addr), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rstmid/quiet", 64'({out_valid, done, busy}), 64'd0);
    end
    run_pass(3, 0, "rerun");

    // Random passes with random backpressure.
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 6);
      fill_random(n);
      run_pass(n, 1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
